if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter, issues requests to instruction memory over a req/ack handshake, and presents `if_instr`/`if_pcplus4` to the IF/ID pipeline register. Honours hazard-unit freezes and branch/jump redirects from ID, and raises `fetch_stall` while memory is slow.

---
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 tb/tb_if_fetch_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC register, imem req/ack handshake, IF/ID presentation, redirects and freezes.
// Define IF_FETCH_BUF_EN to park a word fetched during a freeze in buf_instr instead of re-fetching it.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   freeze,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            if_pcplus4,
    output logic [31:0]            if_instr,
    output logic                   if_valid,
    output logic                   fetch_stall
);

`ifdef IF_FETCH_BUF_EN
    typedef enum logic {REQ, BUF} state_t;
    state_t      state, state_next;
    logic [31:0] buf_instr, buf_instr_next;
`endif

    logic [31:0] pc, pc_next;
    logic [31:0] pc_plus4;
    logic        redir_pend, redir_pend_next;
    logic [31:0] redir_tgt, redir_tgt_next;
    logic        req_raw, valid_raw, stall_raw;
    logic [31:0] instr_raw;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h00000000;
`ifdef IF_FETCH_BUF_EN
            state      <= REQ;
            buf_instr  <= 32'h00000000;
`endif
        end else begin
            pc         <= pc_next;
            redir_pend <= redir_pend_next;
            redir_tgt  <= redir_tgt_next;
`ifdef IF_FETCH_BUF_EN
            state      <= state_next;
            buf_instr  <= buf_instr_next;
`endif
        end
    end

    // The address must not move while a request is unacknowledged, so a redirect
    // arriving mid-wait is parked in redir_tgt and the late word is dropped on ack.
    always_comb begin
        pc_next         = pc;
        redir_pend_next = redir_pend;
        redir_tgt_next  = redir_tgt;
        req_raw         = 1'b0;
        valid_raw       = 1'b0;
        stall_raw       = 1'b0;
        instr_raw       = 32'h00000000;
`ifdef IF_FETCH_BUF_EN
        state_next      = state;
        buf_instr_next  = buf_instr;
        if (state == BUF) begin
            valid_raw = 1'b1;
            instr_raw = buf_instr;
            if (redirect) begin
                pc_next    = redirect_pc;
                state_next = REQ;
            end else if (!freeze) begin
                pc_next    = pc_plus4;
                state_next = REQ;
            end
        end else begin
`endif
            req_raw = 1'b1;
            if (!imem.imem_ack) begin
                stall_raw = 1'b1;
                if (redirect) begin
                    redir_pend_next = 1'b1;
                    redir_tgt_next  = redirect_pc;
                end
            end else if (redir_pend) begin
                redir_pend_next = 1'b0;
                pc_next         = redirect ? redirect_pc : redir_tgt;
            end else begin
                valid_raw = 1'b1;
                instr_raw = imem.imem_rdata;
                if (redirect) begin
                    pc_next = redirect_pc;
                end else if (!freeze) begin
                    pc_next = pc_plus4;
                end
`ifdef IF_FETCH_BUF_EN
                else begin
                    buf_instr_next = imem.imem_rdata;
                    state_next     = BUF;
                end
`endif
            end
`ifdef IF_FETCH_BUF_EN
        end
`endif
    end

    // Reset gates the handshake immediately so memory abandons any open request.
    assign imem.imem_req  = req_raw & ~reset;
    assign imem.imem_addr = pc;
    assign if_pcplus4     = pc_plus4;
    assign if_instr       = reset ? 32'h00000000 : instr_raw;
    assign if_valid       = valid_raw & ~reset;
    assign fetch_stall    = stall_raw & ~reset;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected outputs, a monitor pops and compares.
module tb_if_fetch_unit;

    typedef struct {
        string       name;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic        stall;
        logic [31:0] pcplus4;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_pcplus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        fetch_stall;

    int tests_run;
    int tests_failed;
    exp_t exp_q[$];

    if_fetch_unit_if mem_bus ();

    if_fetch_unit #(.RESET_PC(32'h00400000)) dut (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (mem_bus),
        .if_pcplus4  (if_pcplus4),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .fetch_stall (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One call = one clock cycle: drive inputs just after the rising edge and queue what the DUT must show.
    task automatic applyStimulus(input string nm, input logic rst, input logic fr, input logic rd,
                                 input logic [31:0] rpc, input logic ack, input logic [31:0] rdata,
                                 input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                 input logic [31:0] e_instr, input logic e_stall);
        exp_t e;
        @(posedge clk);
        #1;
        reset               = rst;
        freeze              = fr;
        redirect            = rd;
        redirect_pc         = rpc;
        mem_bus.imem_ack    = ack;
        mem_bus.imem_rdata  = rdata;
        e.name    = nm;
        e.req     = e_req;
        e.addr    = e_addr;
        e.valid   = e_valid;
        e.instr   = e_instr;
        e.stall   = e_stall;
        e.pcplus4 = e_addr + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        tests_run++;
        if (mem_bus.imem_req !== e.req || mem_bus.imem_addr !== e.addr || if_valid !== e.valid ||
            if_instr !== e.instr || fetch_stall !== e.stall || if_pcplus4 !== e.pcplus4) begin
            tests_failed++;
            $display("[TB] FAIL %s: got req=%b addr=%h valid=%b instr=%h stall=%b pc4=%h, expected req=%b addr=%h valid=%b instr=%h stall=%b pc4=%h",
                     e.name, mem_bus.imem_req, mem_bus.imem_addr, if_valid, if_instr, fetch_stall, if_pcplus4,
                     e.req, e.addr, e.valid, e.instr, e.stall, e.pcplus4);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        tests_run          = 0;
        tests_failed       = 0;
        reset              = 1'b1;
        freeze             = 1'b0;
        redirect           = 1'b0;
        redirect_pc        = 32'h0;
        mem_bus.imem_ack   = 1'b0;
        mem_bus.imem_rdata = 32'h0;

        applyStimulus("reset0", 1, 0, 0, 32'h0, 0, 32'h0,        0, 32'h00400000, 0, 32'h0, 0);
        applyStimulus("reset1", 1, 0, 0, 32'h0, 1, 32'h12345678, 0, 32'h00400000, 0, 32'h0, 0);

        // Zero-wait streaming from RESET_PC, last word redirects to 0x10.
        applyStimulus("zw0", 0, 0, 0, 32'h0,  1, 32'h11111111, 1, 32'h00400000, 1, 32'h11111111, 0);
        applyStimulus("zw1", 0, 0, 0, 32'h0,  1, 32'h22222222, 1, 32'h00400004, 1, 32'h22222222, 0);
        applyStimulus("zw2", 0, 0, 1, 32'h10, 1, 32'h33333333, 1, 32'h00400008, 1, 32'h33333333, 0);

        // Three-cycle memory wait at 0x10.
        applyStimulus("wait0", 0, 0, 0, 32'h0,  0, 32'hBAD00000, 1, 32'h10, 0, 32'h0, 1);
        applyStimulus("wait1", 0, 0, 0, 32'h0,  0, 32'hBAD00001, 1, 32'h10, 0, 32'h0, 1);
        applyStimulus("wait2", 0, 0, 0, 32'h0,  0, 32'hBAD00002, 1, 32'h10, 0, 32'h0, 1);
        applyStimulus("waitack", 0, 0, 0, 32'h0, 1, 32'h20000001, 1, 32'h10, 1, 32'h20000001, 0);
        applyStimulus("after_wait", 0, 0, 1, 32'h20, 1, 32'hAAAA0014, 1, 32'h14, 1, 32'hAAAA0014, 0);

        // Freeze for two cycles at 0x20.
        applyStimulus("frz0", 0, 1, 0, 32'h0, 1, 32'h8C010004, 1, 32'h20, 1, 32'h8C010004, 0);
`ifdef IF_FETCH_BUF_EN
        applyStimulus("frz1_buf", 0, 1, 0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h20, 1, 32'h8C010004, 0);
        applyStimulus("frz_rel_buf", 0, 0, 0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h20, 1, 32'h8C010004, 0);
`else
        applyStimulus("frz1", 0, 1, 0, 32'h0, 1, 32'h8C010004, 1, 32'h20, 1, 32'h8C010004, 0);
        applyStimulus("frz_rel", 0, 0, 0, 32'h0, 1, 32'h8C010004, 1, 32'h20, 1, 32'h8C010004, 0);
`endif
        applyStimulus("post_frz", 0, 0, 1, 32'h30, 1, 32'h00000024, 1, 32'h24, 1, 32'h00000024, 0);

        // Redirect arriving during a wait at 0x30 is deferred until the ack.
        applyStimulus("rw0", 0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h30, 0, 32'h0, 1);
        applyStimulus("rw1", 0, 0, 1, 32'h100, 0, 32'h0,        1, 32'h30, 0, 32'h0, 1);
        applyStimulus("rw2", 0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h30, 0, 32'h0, 1);
        applyStimulus("rw_ack_stale", 0, 0, 0, 32'h0, 1, 32'h55555555, 1, 32'h30, 0, 32'h0, 0);
        applyStimulus("rw_target", 0, 0, 1, 32'h40, 1, 32'h00000100, 1, 32'h100, 1, 32'h00000100, 0);

        // Redirect beats freeze: no buffering, next fetch at 0x200.
        applyStimulus("rf0", 0, 1, 1, 32'h200, 1, 32'h40404040, 1, 32'h40, 1, 32'h40404040, 0);
        applyStimulus("rf_target", 0, 0, 1, 32'hFFFFFFFC, 1, 32'h02000000, 1, 32'h200, 1, 32'h02000000, 0);

        // PC wrap-around at the top of the address space.
        applyStimulus("wrap0", 0, 0, 0, 32'h0, 1, 32'hFCFCFCFC, 1, 32'hFFFFFFFC, 1, 32'hFCFCFCFC, 0);
        applyStimulus("wrap1", 0, 0, 0, 32'h0, 1, 32'h0000A000, 1, 32'h0, 1, 32'h0000A000, 0);

        // Reset asserted while a request is pending.
        applyStimulus("pend", 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4, 0, 32'h0, 1);
        applyStimulus("mid_reset", 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h00400000, 0, 32'h0, 0);
        applyStimulus("post_reset_wait", 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h00400000, 0, 32'h0, 1);
        applyStimulus("post_reset_ack", 0, 0, 0, 32'h0, 1, 32'h77777777, 1, 32'h00400000, 1, 32'h77777777, 0);

        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
